// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table and
// polarity helper. Segment order is abcdefg with a in bit 6.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Index 15 first so HEX_TABLE[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex7seg_decoder.sv
// Combinational nibble-to-glyph lookup, active-high abcdefg.
module hex7seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_ah
);

  always_comb begin
    seg_ah = HEX_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with per-scan double buffering,
// blanking, decimal points and an anode-off gap at the start of each slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int GHOST          = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic              SEG_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic              AN_LOW   = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_IDLE = SEG_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_IDLE  = SEG_LOW;
  localparam logic [DIGITS-1:0] AN_IDLE  = AN_LOW ? '1 : '0;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   snap_val_q, snap_val_d;
  logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]     snap_blank_q, snap_blank_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic                  slot_end, last_dig, snap_load;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank, dig_on;
  logic [DIGITS-1:0]     an_onehot;
  logic [6:0]            hex_seg;

  // Scan position and snapshot reload point.
  always_comb begin
    slot_end  = (cnt_q == CW'(DIV - 1));
    last_dig  = (idx_q == IW'(DIGITS - 1));
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    snap_load = 1'b0;
    if (!enable) begin
      cnt_d     = '0;
      idx_d     = '0;
      snap_load = 1'b1;
    end else if (slot_end) begin
      cnt_d     = '0;
      idx_d     = last_dig ? '0 : idx_q + IW'(1);
      snap_load = last_dig;
    end
    snap_val_d   = snap_load ? value  : snap_val_q;
    snap_dp_d    = snap_load ? dp_in  : snap_dp_q;
    snap_blank_d = snap_load ? blank  : snap_blank_q;
  end

  // Select the current digit's snapshot fields without an open-ended index.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = snap_val_q[4*i +: 4];
        cur_dp    = snap_dp_q[i];
        cur_blank = snap_blank_q[i];
      end
    end
  end

  hex7seg_decoder u_dec (
    .nibble (cur_nib),
    .seg_ah (hex_seg)
  );

  always_comb begin
    dig_on    = enable && (cnt_q >= CW'(GHOST)) && !cur_blank;
    an_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_on && (idx_q == IW'(i))) an_onehot[i] = 1'b1;
    end
    seg_d = seg_polarity(dig_on ? hex_seg : SEG_OFF, SEG_LOW);
    dp_d  = (dig_on && cur_dp) ^ SEG_LOW;
    an_d  = AN_LOW ? ~an_onehot : an_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      an_q         <= AN_IDLE;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
